ram_bank_ctl: RTL and testbench
===============================

# ram_bank_ctl

Parametrised successor to the single-bank register-file RAM: one synchronous write port with byte enables, one synchronous read port with read-valid flag, selectable write-first/read-first collision mode, optional output pipeline register, and a built-in clear engine that zeroes the array after reset or on request. Sits between datapath units and local storage wherever a buffer needs known-zero contents and a qualified read result.

## Interface
Parameters:
- ADDR_BIT, 3, address width
- DATA_BIT, 16, word width; must be a multiple of 8
- MEM_HEIGHT, 8, number of words; 1 ≤ MEM_HEIGHT ≤ 2^ADDR_BIT
- RD_BYPASS, 1, 1 = write-first on same-address collision, 0 = read-first
- OUT_REG, 0, 1 = extra output register stage (read latency 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  port enable; gates we/re, not the clear engine
- we  in  1  write request
- be  in  DATA_BIT/8  byte enables, be[i] covers d_w[8i+7:8i]
- addr_w  in  ADDR_BIT  write address
- d_w  in  DATA_BIT  write data
- re  in  1  read request
- addr_r  in  ADDR_BIT  read address
- d_r  out  DATA_BIT  read data
- r_valid  out  1  one-cycle pulse, d_r holds a new read result
- clr  in  1  start a clear sweep
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, IDLE. Reset state CLEAR, clear counter = 0.
- CLEAR: each cycle write 0 to mem[counter], counter++; after writing MEM_HEIGHT-1 go to IDLE. busy = 1 throughout CLEAR. Runs regardless of en.
- IDLE: busy = 0. clr = 1 → CLEAR with counter = 0 next cycle. clr in CLEAR ignored (no restart).
- Accepted write: en & we & !busy & addr_w < MEM_HEIGHT; only bytes with be set are updated. Out-of-range writes dropped.
- Accepted read: en & re & !busy. Out-of-range addr_r returns 0, still flagged valid.
- Collision (accepted write and read, addr_w == addr_r): RD_BYPASS=1 → result = new bytes where be set, old bytes elsewhere; RD_BYPASS=0 → old word.
- Requests with busy = 1 or en = 0 are dropped: no write, no r_valid.
- d_r holds last result until next accepted read; it is not cleared by the clear sweep.
- Memory array itself is not reset; contents are defined only after the first sweep completes.

## Timing
- Reset values: d_r = 0, r_valid = 0, busy = 1, FSM = CLEAR, counter = 0, output pipeline stage = 0/invalid.
- After rst deasserts at edge E0, sweep writes at edges E0..E0+MEM_HEIGHT-1; busy falls after edge E0+MEM_HEIGHT-1 (busy high for exactly MEM_HEIGHT cycles); first request accepted in the following cycle.
- clr sampled in IDLE at edge N → busy = 1 from N, sweep writes at N+1..N+MEM_HEIGHT, busy low after N+MEM_HEIGHT.
- Read latency: OUT_REG=0 → request at edge N, d_r/r_valid valid after N (visible cycle N+1); OUT_REG=1 → after edge N+1. Back-to-back reads every cycle, full throughput.
- Write visible to a separate read issued at the following edge or later.
- rst mid-sweep or mid-read: aborts immediately, pending r_valid dropped, sweep restarts from address 0.
- busy is a registered output, no combinational path from inputs.

## Test plan
- Reset release, MEM_HEIGHT=8: busy high exactly 8 cycles; then reads of addr 0..7 each return 0x0000 with r_valid one cycle after request.
- Write 0xABCD to addr 3 be=2'b11, then be=2'b01 with 0x1234 → read addr 3 returns 0xAB34.
- Same-cycle write 0x5555 (be=11) and read addr 5 holding 0x0F0F: RD_BYPASS=1 → 0x5555; RD_BYPASS=0 → 0x0F0F, following read 0x5555.
- OUT_REG=1, reads of addr 1,2,3 on consecutive cycles → results appear 2 cycles after each, r_valid high 3 consecutive cycles.
- Fill memory, pulse clr, issue we/re during busy → dropped, no r_valid; after sweep all words read 0.
- Assert rst at sweep counter = 4 → busy stays 1, after release sweep restarts at 0 and lasts full MEM_HEIGHT cycles; en=0 with we/re → no write, no r_valid.

Source files
------------

// File: rtl/ram_bank_ctl_if.sv
// Bus bundle for ram_bank_ctl: write port, read port, and clear-engine control.
// The master drives requests and the slave (the RAM controller) returns data and status.
interface ram_bank_ctl_if #(
    parameter int ADDR_BIT = 3,
    parameter int DATA_BIT = 16
);
    logic                  en;
    logic                  we;
    logic [DATA_BIT/8-1:0] be;
    logic [ADDR_BIT-1:0]   addr_w;
    logic [DATA_BIT-1:0]   d_w;
    logic                  re;
    logic [ADDR_BIT-1:0]   addr_r;
    logic [DATA_BIT-1:0]   d_r;
    logic                  r_valid;
    logic                  clr;
    logic                  busy;

    modport master (
        output en, we, be, addr_w, d_w, re, addr_r, clr,
        input  d_r, r_valid, busy
    );

    modport slave (
        input  en, we, be, addr_w, d_w, re, addr_r, clr,
        output d_r, r_valid, busy
    );
endinterface

// File: rtl/ram_bank_ctl.sv
// Single-bank RAM with byte-enabled write, qualified read, selectable collision
// behaviour, optional output register, and a zeroing sweep after reset or on clr.
module ram_bank_ctl #(
    parameter int ADDR_BIT   = 3,
    parameter int DATA_BIT   = 16,
    parameter int MEM_HEIGHT = 8,
    parameter int RD_BYPASS  = 1,
    parameter int OUT_REG    = 0
) (
    input logic          clk,
    input logic          rst,
    ram_bank_ctl_if.slave bus
);
    localparam int                NBYTE  = DATA_BIT / 8;
    localparam logic [ADDR_BIT:0] HEIGHT = (ADDR_BIT + 1)'(MEM_HEIGHT);
    localparam logic [ADDR_BIT-1:0] LAST = ADDR_BIT'(MEM_HEIGHT - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;
    logic                busy;
    logic                w_in_range, r_in_range;
    logic                wr_acc, rd_acc;
    logic [DATA_BIT-1:0] merged;
    logic [DATA_BIT-1:0] rd_data;
    logic [DATA_BIT-1:0] s1_data;
    logic                s1_valid;
    logic [DATA_BIT-1:0] mem [MEM_HEIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr is only honoured from IDLE, so a running sweep is never restarted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == CLEAR);
    assign w_in_range = ({1'b0, bus.addr_w} < HEIGHT);
    assign r_in_range = ({1'b0, bus.addr_r} < HEIGHT);
    assign wr_acc     = bus.en & bus.we & ~busy & w_in_range;
    assign rd_acc     = bus.en & bus.re & ~busy;

    always_comb begin
        merged = mem[bus.addr_w];
        for (int i = 0; i < NBYTE; i++) begin
            if (bus.be[i]) merged[8*i +: 8] = bus.d_w[8*i +: 8];
        end
    end

    // The array has no reset; the sweep is what gives it known contents.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.addr_w] <= merged;
        end
    end

    always_comb begin
        rd_data = '0;
        if (r_in_range) rd_data = mem[bus.addr_r];
        if ((RD_BYPASS != 0) && wr_acc && (bus.addr_w == bus.addr_r)) rd_data = merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) s1_data <= rd_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_BIT-1:0] s2_data;
            logic                s2_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign bus.d_r     = s2_data;
            assign bus.r_valid = s2_valid;
        end else begin : g_no_reg
            assign bus.d_r     = s1_data;
            assign bus.r_valid = s1_valid;
        end
    endgenerate

    assign bus.busy = busy;
endmodule

// File: tb/tb_ram_bank_ctl.sv
// Directed bench for ram_bank_ctl: write-first, read-first and output-register
// variants run side by side on identical stimulus.
module tb_ram_bank_ctl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cycles;

    ram_bank_ctl_if #(.ADDR_BIT(3), .DATA_BIT(16)) if0 ();
    ram_bank_ctl_if #(.ADDR_BIT(3), .DATA_BIT(16)) if1 ();
    ram_bank_ctl_if #(.ADDR_BIT(3), .DATA_BIT(16)) if2 ();

    ram_bank_ctl #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8), .RD_BYPASS(1), .OUT_REG(0))
        dut_wf (.clk(clk), .rst(rst), .bus(if0.slave));
    ram_bank_ctl #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8), .RD_BYPASS(0), .OUT_REG(0))
        dut_rf (.clk(clk), .rst(rst), .bus(if1.slave));
    ram_bank_ctl #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8), .RD_BYPASS(1), .OUT_REG(1))
        dut_or (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if1.en = if0.en;       assign if2.en = if0.en;
    assign if1.we = if0.we;       assign if2.we = if0.we;
    assign if1.be = if0.be;       assign if2.be = if0.be;
    assign if1.addr_w = if0.addr_w; assign if2.addr_w = if0.addr_w;
    assign if1.d_w = if0.d_w;     assign if2.d_w = if0.d_w;
    assign if1.re = if0.re;       assign if2.re = if0.re;
    assign if1.addr_r = if0.addr_r; assign if2.addr_r = if0.addr_r;
    assign if1.clr = if0.clr;     assign if2.clr = if0.clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] b, input logic [2:0] aw,
                                 input logic [15:0] dw, input logic r, input logic [2:0] ar);
        if0.we     = w;
        if0.be     = b;
        if0.addr_w = aw;
        if0.d_w    = dw;
        if0.re     = r;
        if0.addr_r = ar;
    endtask

    task automatic waitSweep(input int expected, input string tag);
        cycles = 0;
        while (if0.busy && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 16'(cycles), 16'(expected));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        if0.en = 1'b1;
        if0.clr = 1'b0;
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 16'(if0.busy), 16'h1);
        checkOutput("rst_valid", 16'(if0.r_valid), 16'h0);
        checkOutput("rst_dr", if0.d_r, 16'h0);
        checkOutput("rst_valid_or", 16'(if2.r_valid), 16'h0);

        // Boot sweep, then every word must read back as zero.
        rst = 1'b0;
        waitSweep(8, "boot_busy_len");
        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'(a));
            @(negedge clk);
            checkOutput("boot_rd_valid", 16'(if0.r_valid), 16'h1);
            checkOutput("boot_rd_data", if0.d_r, 16'h0);
        end
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        @(negedge clk);
        checkOutput("valid_pulse", 16'(if0.r_valid), 16'h0);

        // Byte-enable merge.
        applyStimulus(1, 2'b11, 3'd3, 16'hABCD, 0, 3'd0);
        @(negedge clk);
        applyStimulus(1, 2'b01, 3'd3, 16'h1234, 0, 3'd0);
        @(negedge clk);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd3);
        @(negedge clk);
        checkOutput("be_merge_wf", if0.d_r, 16'hAB34);
        checkOutput("be_merge_rf", if1.d_r, 16'hAB34);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        @(negedge clk);
        checkOutput("be_merge_or", if2.d_r, 16'hAB34);

        // Same-address collision.
        applyStimulus(1, 2'b11, 3'd5, 16'h0F0F, 0, 3'd0);
        @(negedge clk);
        applyStimulus(1, 2'b11, 3'd5, 16'h5555, 1, 3'd5);
        @(negedge clk);
        checkOutput("coll_write_first", if0.d_r, 16'h5555);
        checkOutput("coll_read_first", if1.d_r, 16'h0F0F);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd5);
        @(negedge clk);
        checkOutput("coll_after_rf", if1.d_r, 16'h5555);

        // Output-register latency with back-to-back reads.
        applyStimulus(1, 2'b11, 3'd1, 16'h1111, 0, 3'd0);
        @(negedge clk);
        applyStimulus(1, 2'b11, 3'd2, 16'h2222, 0, 3'd0);
        @(negedge clk);
        applyStimulus(1, 2'b11, 3'd3, 16'h3333, 0, 3'd0);
        @(negedge clk);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd1);
        @(negedge clk);
        checkOutput("or_lat_not_yet", 16'(if2.r_valid), 16'h0);
        checkOutput("wf_lat_rd1", if0.d_r, 16'h1111);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd2);
        @(negedge clk);
        checkOutput("or_rd1_valid", 16'(if2.r_valid), 16'h1);
        checkOutput("or_rd1_data", if2.d_r, 16'h1111);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd3);
        @(negedge clk);
        checkOutput("or_rd2_valid", 16'(if2.r_valid), 16'h1);
        checkOutput("or_rd2_data", if2.d_r, 16'h2222);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        @(negedge clk);
        checkOutput("or_rd3_valid", 16'(if2.r_valid), 16'h1);
        checkOutput("or_rd3_data", if2.d_r, 16'h3333);
        @(negedge clk);
        checkOutput("or_valid_drop", 16'(if2.r_valid), 16'h0);
        checkOutput("or_data_hold", if2.d_r, 16'h3333);

        // Fill, then clear on request; requests during the sweep are dropped.
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1, 2'b11, 3'(a), 16'hF000 | 16'(a), 0, 3'd0);
            @(negedge clk);
        end
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd6);
        @(negedge clk);
        checkOutput("fill_rd6", if0.d_r, 16'hF006);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        if0.clr = 1'b1;
        @(negedge clk);
        if0.clr = 1'b0;
        checkOutput("clr_busy", 16'(if0.busy), 16'h1);
        @(negedge clk);
        applyStimulus(1, 2'b11, 3'd0, 16'hBEEF, 1, 3'd6);
        @(negedge clk);
        checkOutput("busy_rd_dropped", 16'(if0.r_valid), 16'h0);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        waitSweep(6, "clr_busy_len");
        checkOutput("dr_hold_sweep", if0.d_r, 16'hF006);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'(a));
            @(negedge clk);
            checkOutput("clr_rd_data", if0.d_r, 16'h0);
        end
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);

        // Reset in the middle of a sweep restarts it from address 0.
        if0.clr = 1'b1;
        @(negedge clk);
        if0.clr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midsweep_rst_busy", 16'(if0.busy), 16'h1);
        @(negedge clk);
        rst = 1'b0;
        waitSweep(8, "restart_busy_len");

        // Disabled port drops requests.
        if0.en = 1'b0;
        applyStimulus(1, 2'b11, 3'd4, 16'h7777, 1, 3'd4);
        @(negedge clk);
        checkOutput("en0_no_valid", 16'(if0.r_valid), 16'h0);
        if0.en = 1'b1;
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd4);
        @(negedge clk);
        checkOutput("en0_no_write", if0.d_r, 16'h0);

        // Reset while a registered read is in flight drops it.
        applyStimulus(1, 2'b11, 3'd1, 16'h4242, 0, 3'd0);
        @(negedge clk);
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 1, 3'd1);
        @(negedge clk);
        checkOutput("preflight_wf", if0.d_r, 16'h4242);
        rst = 1'b1;
        applyStimulus(0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        #1;
        checkOutput("rst_dr_clear", if0.d_r, 16'h0);
        @(negedge clk);
        checkOutput("rst_drop_or_valid", 16'(if2.r_valid), 16'h0);
        checkOutput("rst_drop_or_data", if2.d_r, 16'h0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
